keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller: drives one row low at a time, debounces
// a single pressed key, and hands the key code to a consumer with a dav/ack handshake.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COLS-1:0]                 col,
    input  logic                            ack,
    output logic [ROWS-1:0]                 row,
    output logic [$clog2(ROWS*COLS)-1:0]    code,
    output logic                            dav,
    output logic                            overrun,
    output logic                            released
);

    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int DW     = $clog2(SCAN_DIV);
    localparam int MW     = $clog2(DEBOUNCE+1);

    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV-1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS-1);
    localparam logic [MW-1:0]   DEB_M      = MW'(DEBOUNCE);
    localparam logic [ROWS-1:0] ROW_RESET  = {{(ROWS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD
    } state_t;

    state_t              r_state;
    logic [ROWS-1:0]     r_row;
    logic [RW-1:0]       r_row_idx;
    logic [DW-1:0]       r_dwell;
    logic [CW-1:0]       r_cand_c;
    logic [MW-1:0]       r_match;
    logic [MW-1:0]       r_rel;
    logic [CODE_W-1:0]   r_code;
    logic                r_dav;
    logic                r_overrun;
    logic                r_released;

    logic [COLS-1:0]     w_col_low;
    logic                w_single;
    logic [CW-1:0]       w_key_c;
    logic                w_sample;
    logic                w_match_ok;
    logic                w_accept;
    logic [CODE_W-1:0]   w_acc_code;
    logic [MW-1:0]       w_match_inc;
    logic [MW-1:0]       w_rel_inc;
    logic [ROWS-1:0]     w_row_next;
    logic [RW-1:0]       w_idx_next;

    function automatic logic [CODE_W-1:0] key_code(input logic [RW-1:0] r, input logic [CW-1:0] c);
        int v;
        v = int'(r) * COLS + int'(c);
        return CODE_W'(v);
    endfunction

    // A sample is a key only when exactly one column is pulled low.
    assign w_col_low = ~col;
    assign w_single  = (|w_col_low) && ((w_col_low & (w_col_low - COLS'(1))) == '0);

    always_comb begin
        w_key_c = '0;
        for (int i = 0; i < COLS; i++) begin
            if (w_col_low[i]) begin
                w_key_c = CW'(i);
            end
        end
    end

    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_match_ok  = w_single && (w_key_c == r_cand_c);
    assign w_match_inc = r_match + MW'(1);
    assign w_rel_inc   = r_rel + MW'(1);
    assign w_row_next  = {r_row[ROWS-2:0], r_row[ROWS-1]};
    assign w_idx_next  = (r_row_idx == ROW_LAST) ? '0 : r_row_idx + RW'(1);
    assign w_acc_code  = key_code(r_row_idx, w_key_c);

    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            S_SCAN:     w_accept = w_sample && w_single && (DEBOUNCE == 1);
            S_DEBOUNCE: w_accept = w_sample && w_match_ok && (w_match_inc == DEB_M);
            default:    w_accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_SCAN;
            r_row      <= ROW_RESET;
            r_row_idx  <= '0;
            r_dwell    <= '0;
            r_cand_c   <= '0;
            r_match    <= '0;
            r_rel      <= '0;
            r_code     <= '0;
            r_dav      <= 1'b0;
            r_overrun  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_released <= 1'b0;
            r_dwell    <= w_sample ? '0 : r_dwell + DW'(1);

            if (w_sample) begin
                case (r_state)
                    S_SCAN: begin
                        if (w_single) begin
                            r_cand_c <= w_key_c;
                            r_match  <= MW'(1);
                            r_rel    <= '0;
                            r_state  <= w_accept ? S_HOLD : S_DEBOUNCE;
                        end else begin
                            r_row     <= w_row_next;
                            r_row_idx <= w_idx_next;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_match_ok) begin
                            r_match <= w_match_inc;
                            if (w_accept) begin
                                r_state <= S_HOLD;
                                r_rel   <= '0;
                            end
                        end else begin
                            r_state   <= S_SCAN;
                            r_match   <= '0;
                            r_row     <= w_row_next;
                            r_row_idx <= w_idx_next;
                        end
                    end
                    S_HOLD: begin
                        // Row stays frozen until the key has read as released long enough.
                        if (col == '1) begin
                            if (w_rel_inc == DEB_M) begin
                                r_released <= 1'b1;
                                r_state    <= S_SCAN;
                                r_rel      <= '0;
                                r_match    <= '0;
                                r_row      <= w_row_next;
                                r_row_idx  <= w_idx_next;
                            end else begin
                                r_rel <= w_rel_inc;
                            end
                        end else begin
                            r_rel <= '0;
                        end
                    end
                    default: r_state <= S_SCAN;
                endcase
            end

            // An acceptance wins over ack; a simultaneous ack only clears overrun.
            if (w_accept) begin
                r_code <= w_acc_code;
                r_dav  <= 1'b1;
                if (r_dav) begin
                    r_overrun <= ~ack;
                end
            end else if (ack && r_dav) begin
                r_dav     <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign row      = r_row;
    assign code     = r_code;
    assign dav      = r_dav;
    assign overrun  = r_overrun;
    assign released = r_released;

endmodule
